// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: bubble instruction, BTB entry layout and
// 2-bit branch-predictor counter states.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag is kept at full width; unused upper bits are constant and trim away.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational lookup port, clocked update port.
module btb
    import riscv_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic [31:0] target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_taken_i
);

    localparam int N = 1 << IDX_W;

    btb_entry_t       tab_q [N];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [31:0]      lk_tag;
    logic [31:0]      up_tag;
    btb_entry_t       lk_e;
    btb_entry_t       up_e;
    btb_entry_t       up_d;
    logic             up_match;

    assign lk_idx   = lookup_pc_i[IDX_W+1:2];
    assign lk_tag   = lookup_pc_i >> (IDX_W + 2);
    assign lk_e     = tab_q[lk_idx];
    assign hit_o    = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
    assign target_o = lk_e.target;

    assign up_idx   = upd_pc_i[IDX_W+1:2];
    assign up_tag   = upd_pc_i >> (IDX_W + 2);
    assign up_e     = tab_q[up_idx];
    assign up_match = up_e.valid && (up_e.tag == up_tag);

    always_comb begin
        up_d = up_e;
        if (upd_taken_i) begin
            if (up_match) begin
                up_d.target = upd_target_i;
                up_d.ctr    = (up_e.ctr == ST) ? ST : up_e.ctr + 2'd1;
            end else begin
                up_d.valid  = 1'b1;
                up_d.tag    = up_tag;
                up_d.target = upd_target_i;
                up_d.ctr    = WT;
            end
        end else if (up_match) begin
            up_d.ctr = (up_e.ctr == SNT) ? SNT : up_e.ctr - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                tab_q[i] <= '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: WNT};
            end
        end else if (upd_valid_i) begin
            tab_q[up_idx] <= up_d;
        end
    end

endmodule

// File: rtl/if_stage_btb.sv
// Instruction-fetch stage: PC register, BTB-predicted next PC and the IF/ID
// pipeline register feeding decode.
module if_stage_btb #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4,
    parameter logic [31:0] NOP_INST  = riscv_pkg::NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        reset_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_taken_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] inst_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc4_d_o,
    output logic        hit_d_o
);

    logic [31:0] pc_q,   pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q,  ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        hit_q,  hit_d;
    logic        pred_hit;
    logic [31:0] pred_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] pred_pc;

    btb #(.IDX_W(BTB_IDX_W)) u_btb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_pc_i  (pc_q),
        .hit_o        (pred_hit),
        .target_o     (pred_tgt),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign pred_pc  = pred_hit ? pred_tgt : pc_plus4;

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        ipc_d  = ipc_q;
        ipc4_d = ipc4_q;
        hit_d  = hit_q;
        if (redirect_i) begin
            pc_d   = redirect_pc_i;
            inst_d = NOP_INST;
            ipc_d  = 32'd0;
            ipc4_d = 32'd0;
            hit_d  = 1'b0;
        end else if (enable_i) begin
            if (imem_ready_i) begin
                pc_d = pred_pc;
            end
            // A flush still lets the accepted word advance the PC.
            if (reset_i || !imem_ready_i) begin
                inst_d = NOP_INST;
                ipc_d  = 32'd0;
                ipc4_d = 32'd0;
                hit_d  = 1'b0;
            end else begin
                inst_d = imem_rdata_i;
                ipc_d  = pc_q;
                ipc4_d = pc_plus4;
                hit_d  = pred_hit;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
            ipc_q  <= 32'd0;
            ipc4_q <= 32'd0;
            hit_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            ipc_q  <= ipc_d;
            ipc4_q <= ipc4_d;
            hit_q  <= hit_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign imem_req_o  = rst_ni;
    assign inst_d_o    = inst_q;
    assign pc_d_o      = ipc_q;
    assign pc4_d_o     = ipc4_q;
    assign hit_d_o     = hit_q;

endmodule

// File: tb/tb_if_stage_btb.sv
// Directed bench for if_stage_btb: driver pushes hand-computed post-edge
// expectations into a queue; a negedge monitor pops and compares them.
module tb_if_stage_btb;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic        hit_d;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_stage_btb dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .reset_i       (flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .upd_valid_i   (upd_valid),
        .upd_pc_i      (upd_pc),
        .upd_target_i  (upd_target),
        .upd_taken_i   (upd_taken),
        .imem_addr_o   (imem_addr),
        .imem_req_o    (imem_req),
        .imem_rdata_i  (imem_rdata),
        .imem_ready_i  (imem_ready),
        .inst_d_o      (inst_d),
        .pc_d_o        (pc_d),
        .pc4_d_o       (pc4_d),
        .hit_d_o       (hit_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] w(input int n);
        return 32'hC0DE_0000 + n;
    endfunction

    // One clock: drive inputs, then queue the expected state after the edge.
    task automatic cyc(input logic en, input logic fl, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rdata,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utg, input logic utk,
                       input logic [31:0] e_addr, input logic [31:0] e_inst, input logic [31:0] e_pc,
                       input logic [31:0] e_pc4, input logic e_hit);
        exp_t e;
        enable      = en;
        flush       = fl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rdata;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_target  = utg;
        upd_taken   = utk;
        @(posedge clk);
        #1;
        e.addr = e_addr;
        e.inst = e_inst;
        e.pc   = e_pc;
        e.pc4  = e_pc4;
        e.hit  = e_hit;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Convenience: plain fetch with no update / flush / redirect.
    task automatic fetch(input logic [31:0] rdata, input logic [31:0] e_addr, input logic [31:0] e_inst,
                         input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic e_hit);
        cyc(1, 0, 0, 0, 1, rdata, 0, 0, 0, 0, e_addr, e_inst, e_pc, e_pc4, e_hit);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("inst_d", inst_d, e.inst);
                chk("pc_d", pc_d, e.pc);
                chk("pc4_d", pc4_d, e.pc4);
                chk("hit_d", {31'd0, hit_d}, {31'd0, e.hit});
            end
        end
    end

    initial begin : driver
        int budget;
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        imem_rdata = '0; imem_ready = 1'b0;
        #12;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_inst", inst_d, NOP);
        chk("rst_pc", pc_d, 32'd0);
        chk("rst_pc4", pc4_d, 32'd0);
        chk("rst_hit", {31'd0, hit_d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_after_rst", {31'd0, imem_req}, 32'd1);
        @(negedge clk);

        // sequential fetch
        fetch(w(0), 32'h04, w(0), 32'h00, 32'h04, 0);
        fetch(w(1), 32'h08, w(1), 32'h04, 32'h08, 0);
        fetch(w(2), 32'h0C, w(2), 32'h08, 32'h0C, 0);
        fetch(w(3), 32'h10, w(3), 32'h0C, 32'h10, 0);
        // three-cycle imem stall at 0x10
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h10, NOP, 0, 0, 0);
        fetch(w(4), 32'h14, w(4), 32'h10, 32'h14, 0);
        // train 0x20 -> 0x80 twice taken
        cyc(1, 0, 0, 0, 1, w(5), 1, 32'h20, 32'h80, 1, 32'h18, w(5), 32'h14, 32'h18, 0);
        cyc(1, 0, 0, 0, 1, w(6), 1, 32'h20, 32'h80, 1, 32'h1C, w(6), 32'h18, 32'h1C, 0);
        fetch(w(7), 32'h20, w(7), 32'h1C, 32'h20, 0);
        fetch(w(8), 32'h80, w(8), 32'h20, 32'h24, 1);
        fetch(w(9), 32'h84, w(9), 32'h80, 32'h84, 0);
        // two not-taken: counter 11 -> 10 -> 01
        cyc(1, 0, 0, 0, 1, w(10), 1, 32'h20, 32'h0, 0, 32'h88, w(10), 32'h84, 32'h88, 0);
        cyc(1, 0, 0, 0, 1, w(11), 1, 32'h20, 32'h0, 0, 32'h8C, w(11), 32'h88, 32'h8C, 0);
        cyc(1, 0, 1, 32'h20, 1, w(99), 0, 0, 0, 0, 32'h20, NOP, 0, 0, 0);
        fetch(w(12), 32'h24, w(12), 32'h20, 32'h24, 0);
        // redirect wins over stall
        cyc(0, 0, 1, 32'h100, 1, w(99), 0, 0, 0, 0, 32'h100, NOP, 0, 0, 0);
        fetch(w(13), 32'h104, w(13), 32'h100, 32'h104, 0);
        cyc(0, 0, 0, 0, 1, w(98), 0, 0, 0, 0, 32'h104, w(13), 32'h100, 32'h104, 0);
        cyc(0, 1, 0, 0, 0, w(97), 0, 0, 0, 0, 32'h104, w(13), 32'h100, 32'h104, 0);
        // flush: bubble but PC advances
        cyc(1, 1, 0, 0, 1, w(14), 0, 0, 0, 0, 32'h108, NOP, 0, 0, 0);
        fetch(w(15), 32'h10C, w(15), 32'h108, 32'h10C, 0);
        // same-index update during lookup sees old entry
        cyc(1, 0, 1, 32'h40, 1, w(99), 0, 0, 0, 0, 32'h40, NOP, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, w(16), 1, 32'h40, 32'h200, 1, 32'h44, w(16), 32'h40, 32'h44, 0);
        cyc(1, 0, 1, 32'h40, 1, w(99), 0, 0, 0, 0, 32'h40, NOP, 0, 0, 0);
        fetch(w(17), 32'h200, w(17), 32'h40, 32'h44, 1);
        // same index as 0x40, different tag: no hit
        fetch(w(18), 32'h204, w(18), 32'h200, 32'h204, 0);
        // PC+4 wraps at top of address space
        cyc(1, 0, 1, 32'hFFFF_FFFC, 1, w(99), 0, 0, 0, 0, 32'hFFFF_FFFC, NOP, 0, 0, 0);
        fetch(w(19), 32'h0, w(19), 32'hFFFF_FFFC, 32'h0, 0);
        // park in a stall at 0x30
        cyc(1, 0, 1, 32'h30, 1, w(99), 0, 0, 0, 0, 32'h30, NOP, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, w(99), 0, 0, 0, 0, 32'h30, NOP, 0, 0, 0);

        budget = 10;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        // asynchronous reset mid-cycle during the stall
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_addr", imem_addr, 32'h0);
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_inst", inst_d, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(w(20), 32'h04, w(20), 32'h00, 32'h04, 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
